// File: rtl/adder_pkg.sv
// Shared widths, types and the reference Kogge-Stone level function for the 32-bit adder.
package adder_pkg;

    localparam int ADD_WIDTH     = 32;
    localparam int PG_WIDTH      = ADD_WIDTH + 1;
    localparam int PREFIX_LEVELS = 6;

    typedef logic [PG_WIDTH-1:0] pg_vec_t;

    typedef struct packed {
        pg_vec_t g;
        pg_vec_t p;
    } pg_pair_t;

    // One radix-2 level: bits below the span pass through untouched.
    function automatic pg_pair_t kogge_stone_level(input pg_vec_t g, input pg_vec_t p, input int k);
        pg_pair_t r;
        int       d;
        d   = 1 << k;
        r.g = g;
        r.p = p;
        for (int i = 0; i < PG_WIDTH; i++) begin
            if (i >= d) begin
                r.g[i] = g[i] | (p[i] & g[i-d]);
                r.p[i] = p[i] & p[i-d];
            end
        end
        return r;
    endfunction

    function automatic int stage_count(input logic [PREFIX_LEVELS-1:0] mask);
        int n;
        n = 0;
        for (int k = 0; k < PREFIX_LEVELS; k++) begin
            n = n + int'(mask[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/black_cell.sv
// Prefix-tree combine cell: merges a high (g,p) group with the adjacent low group.
module black_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_o,
    output logic p_o
);

    assign g_o = g_hi | (p_hi & g_lo);
    assign p_o = p_hi & p_lo;

endmodule

// File: rtl/prefix_tree_pipelined_32b.sv
// Kogge-Stone carry network over 33 propagate/generate bits (bit 0 = carry-in),
// with an optional valid/ready register slice after each tree level.
module prefix_tree_pipelined_32b
    import adder_pkg::*;
#(
    parameter logic [PREFIX_LEVELS-1:0] PIPE_MASK = 6'b000100
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [PG_WIDTH-1:0] prop_i,
    input  logic [PG_WIDTH-1:0] gen_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [PG_WIDTH-1:0] prop_o,
    output logic [PG_WIDTH-1:0] carry_o
);

    localparam int WIDTH = PG_WIDTH;

    for (genvar k = 0; k < PREFIX_LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;

        pg_vec_t w_g_in;
        pg_vec_t w_p_in;
        pg_vec_t w_prop_in;
        pg_vec_t w_g_cmb;
        pg_vec_t w_p_cmb;
        pg_vec_t w_g_q;
        pg_vec_t w_p_q;
        pg_vec_t w_prop_q;
        logic    w_v_in;
        logic    w_v_q;
        logic    w_rdy_in;
        logic    w_rdy_out;

        if (k == 0) begin : g_head
            assign w_g_in    = gen_i;
            assign w_p_in    = prop_i;
            assign w_prop_in = prop_i;
            assign w_v_in    = valid_i;
        end else begin : g_link
            assign w_g_in    = g_lvl[k-1].w_g_q;
            assign w_p_in    = g_lvl[k-1].w_p_q;
            assign w_prop_in = g_lvl[k-1].w_prop_q;
            assign w_v_in    = g_lvl[k-1].w_v_q;
        end

        // Ready ripples backward from the sink; only a register slice can break it.
        if (k == PREFIX_LEVELS-1) begin : g_tail
            assign w_rdy_out = ready_i;
        end else begin : g_back
            assign w_rdy_out = g_lvl[k+1].w_rdy_in;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                black_cell u_cell (
                    .g_hi (w_g_in[i]),
                    .p_hi (w_p_in[i]),
                    .g_lo (w_g_in[i-D]),
                    .p_lo (w_p_in[i-D]),
                    .g_o  (w_g_cmb[i]),
                    .p_o  (w_p_cmb[i])
                );
            end else begin : g_pass
                assign w_g_cmb[i] = w_g_in[i];
                assign w_p_cmb[i] = w_p_in[i];
            end
        end

        if (PIPE_MASK[k]) begin : g_reg
            logic    r_v;
            pg_vec_t r_g;
            pg_vec_t r_p;
            pg_vec_t r_prop;

            // An empty slot always loads, so bubbles collapse under a downstream stall.
            assign w_rdy_in = !r_v || w_rdy_out;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_v    <= 1'b0;
                    r_g    <= '0;
                    r_p    <= '0;
                    r_prop <= '0;
                end else if (w_rdy_in) begin
                    r_v    <= w_v_in;
                    r_g    <= w_g_cmb;
                    r_p    <= w_p_cmb;
                    r_prop <= w_prop_in;
                end
            end

            assign w_v_q    = r_v;
            assign w_g_q    = r_g;
            assign w_p_q    = r_p;
            assign w_prop_q = r_prop;
        end else begin : g_wire
            assign w_rdy_in = w_rdy_out;
            assign w_v_q    = w_v_in;
            assign w_g_q    = w_g_cmb;
            assign w_p_q    = w_p_cmb;
            assign w_prop_q = w_prop_in;
        end
    end

    // The final group propagate has no consumer; post-processing uses the original prop.
    logic w_unused_p;
    assign w_unused_p = ^g_lvl[PREFIX_LEVELS-1].w_p_q;

    assign ready_o = g_lvl[0].w_rdy_in;
    assign valid_o = g_lvl[PREFIX_LEVELS-1].w_v_q;
    assign carry_o = g_lvl[PREFIX_LEVELS-1].w_g_q;
    assign prop_o  = g_lvl[PREFIX_LEVELS-1].w_prop_q;

endmodule
